// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the register-sharing arbiter: state encoding and default sizing.
package reg_share_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned HOLD_CYC_DEF = 2;

  // Hold counter width; HOLD_CYC tops out at 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the register-sharing arbiter.
interface reg_share_arbiter_if
  import reg_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qbar;
  logic [IDX_W-1:0]       owner;
  logic                   busy;
  logic                   valid;

  // Requesters drive writes and observe the shared register.
  modport master (
    output req, wdata,
    input  gnt, q, qbar, owner, busy, valid
  );

  // The arbiter consumes writes and publishes the shared register.
  modport slave (
    input  req, wdata,
    output gnt, q, qbar, owner, busy, valid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  int unsigned        sum;

  // Rotate req so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    dbl   = {req, req} >> ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        sum   = 32'(ptr) + i;
        if (sum >= N_REQ) begin
          sum = sum - N_REQ;
        end
        idx = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting single writes into one shared register with a hold window.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
  input logic                clk,
  input logic                rst,
  reg_share_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found;
  logic [IDX_W-1:0]   win;
  logic [WIDTH-1:0]   slices [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  // Unpack the write data so the winner's slice is a plain array select.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      slices[i] = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  // Next-state: capture the winner on leaving IDLE, then count down the hold window.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          data_d  = slices[win];
          owner_d = win;
          gnt_d   = N_REQ'(1) << win;
          valid_d = 1'b1;
          ptr_d   = (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Requests are ignored here; IDLE is always visited before the next grant.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.q     = data_q;
  assign bus.qbar  = ~data_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == BUSY);
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed self-checking bench for reg_share_arbiter.
module tb_reg_share_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  reg_share_arbiter #(
    .N_REQ    (4),
    .WIDTH    (8),
    .HOLD_CYC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.req   = '0;
    bus.wdata = '0;
    tick();
    tick();
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", bus.q); end
    checks++; if (bus.qbar !== 8'hFF) begin errors++; $display("FAIL reset_qbar got %h exp FF", bus.qbar); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", bus.owner); end
  endtask

  task automatic test_single();
    rst = 1'b0;
    bus.wdata[8 +: 8] = 8'hA5;
    bus.req = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got %b exp 0010", bus.gnt); end
    checks++; if (bus.q !== 8'hA5) begin errors++; $display("FAIL single_q got %h exp A5", bus.q); end
    checks++; if (bus.qbar !== 8'h5A) begin errors++; $display("FAIL single_qbar got %h exp 5A", bus.qbar); end
    checks++; if (bus.owner !== 2'd1) begin errors++; $display("FAIL single_owner got %0d exp 1", bus.owner); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.valid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b exp 1", bus.busy); end
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse got %b exp 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy2 got %b exp 1", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", bus.busy); end
    checks++; if (bus.q !== 8'hA5) begin errors++; $display("FAIL single_q_hold got %h exp A5", bus.q); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      exp_q = 8'h10 + 8'(g % 4);
      tick();
      checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL contend_gnt%0d got %b exp %b", g, bus.gnt, exp_g); end
      checks++; if (bus.q !== exp_q) begin errors++; $display("FAIL contend_q%0d got %h exp %h", g, bus.q, exp_q); end
      checks++; if (bus.owner !== 2'(g % 4)) begin errors++; $display("FAIL contend_owner%0d got %0d exp %0d", g, bus.owner, g % 4); end
      tick();
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL contend_gap_a%0d got %b exp 0000", g, bus.gnt); end
      tick();
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL contend_gap_b%0d got %b exp 0000", g, bus.gnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL contend_idle%0d got %b exp 0", g, bus.busy); end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_busy_req();
    bus.wdata[16 +: 8] = 8'h77;
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL busyreq_gnt0 got %b exp 0001", bus.gnt); end
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL busyreq_hold_a got %b exp 0000", bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL busyreq_hold_b got %b exp 0000", bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL busyreq_gnt2 got %b exp 0100", bus.gnt); end
    checks++; if (bus.q !== 8'h77) begin errors++; $display("FAIL busyreq_q got %h exp 77", bus.q); end
    checks++; if (bus.owner !== 2'd2) begin errors++; $display("FAIL busyreq_owner got %0d exp 2", bus.owner); end
    bus.req = 4'b0000;
  endtask

  task automatic test_withdraw();
    bus.wdata[24 +: 8] = 8'hEE;
    bus.req = 4'b1000;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL withdraw_gnt_a got %b exp 0000", bus.gnt); end
    bus.req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL withdraw_gnt%0d got %b exp 0000", k, bus.gnt); end
    end
    checks++; if (bus.q !== 8'h77) begin errors++; $display("FAIL withdraw_q got %h exp 77", bus.q); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL withdraw_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_mid_busy_reset();
    bus.wdata[16 +: 8] = 8'h55;
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL midrst_gnt2 got %b exp 0100", bus.gnt); end
    checks++; if (bus.q !== 8'h55) begin errors++; $display("FAIL midrst_q55 got %h exp 55", bus.q); end
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy2 got %b exp 1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL midrst_q got %h exp 00", bus.q); end
    checks++; if (bus.qbar !== 8'hFF) begin errors++; $display("FAIL midrst_qbar got %h exp FF", bus.qbar); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus.valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    rst = 1'b0;
    bus.wdata[0 +: 8]  = 8'h3C;
    bus.wdata[24 +: 8] = 8'hC3;
    bus.req = 4'b1001;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL midrst_first_gnt got %b exp 0001", bus.gnt); end
    checks++; if (bus.q !== 8'h3C) begin errors++; $display("FAIL midrst_first_q got %h exp 3C", bus.q); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_contention();
    test_busy_req();
    test_withdraw();
    test_mid_busy_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- HOLD_CYC, 2, cycles the shared register is busy after each write (1..15)
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester write request, level
- wdata  in  N_REQ*WIDTH  packed write data, slice i belongs to requester i
- gnt  out  N_REQ  one-hot grant/ack pulse
- q  out  WIDTH  shared register contents
- qbar  out  WIDTH  bitwise complement of q
- owner  out  clog2(N_REQ)  index of the last writer
- busy  out  1  shared register in hold window
- valid  out  1  q written at least once since reset

Function
REQ-003 The FSM SHALL have two states: IDLE and BUSY.
REQ-004 In IDLE with any req bit set, the winner SHALL be the first set bit at or after the round-robin pointer ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-005 On the edge that leaves IDLE with a winner w, the block SHALL set q<=wdata[w], owner<=w, gnt<=one-hot(w), valid<=1, ptr<=(w+1) mod N_REQ, and state<=BUSY.
REQ-006 gnt SHALL be high for exactly one cycle per write, the first BUSY cycle, and zero otherwise.
REQ-007 Grant latency SHALL be one cycle: req sampled high in IDLE at edge k gives gnt high after edge k.
REQ-008 BUSY SHALL last exactly HOLD_CYC cycles; busy=1 throughout and req is ignored.
REQ-009 After BUSY the FSM SHALL return to IDLE for at least one cycle, so back-to-back writes are spaced HOLD_CYC+1 cycles apart.
REQ-010 With no req set in IDLE, q, owner, ptr and valid SHALL hold and gnt SHALL be 0.
REQ-011 qbar SHALL equal ~q combinationally at all times.
REQ-012 A requester SHALL hold req until it sees its gnt bit; deasserting req before grant withdraws the request with no error.
REQ-013 A requester whose req stays high after grant SHALL be re-arbitrated normally in the next IDLE cycle.
REQ-014 The wrap rule SHALL apply when ptr=N_REQ-1, so that with all requests active the grant order is N_REQ-1, 0, 1, ...
REQ-015 wdata of non-winning requesters SHALL never affect q.

Reset
REQ-016 When rst=1, the block SHALL immediately force: state=IDLE, q=0, qbar=all ones, owner=0, gnt=0, busy=0, valid=0, ptr=0, hold counter=0.
REQ-017 A reset asserted mid-BUSY SHALL abort the hold window; the first arbitration after release SHALL start from ptr=0.
REQ-018 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge at which rst is low.

Structure
REQ-019 A shared package SHALL hold the state encoding (IDLE=0, BUSY=1) and the default N_REQ, WIDTH and HOLD_CYC values.
REQ-020 The round-robin winner search SHALL be a combinational sub-module, rr_pick, with inputs req and ptr and outputs found and idx.
REQ-021 q and qbar storage SHALL be the only WIDTH-wide state; the hold counter SHALL be 4 bits.

Verification
REQ-022 Reset then a single request: reset, release, req=0010 with wdata[1]=8'hA5 -> gnt=0010 for one cycle after the next edge, q=A5, qbar=5A, owner=1, valid=1, busy=1 for 2 cycles.
REQ-023 Full contention: req=1111 held, wdata[i]=8'h10+i -> grants 0001, 0010, 0100, 1000, 0001, each 3 cycles apart, q=10, 11, 12, 13, 10.
REQ-024 Request during BUSY: req[2] rises in the first BUSY cycle after a grant to requester 0 -> no gnt until IDLE, then gnt=0100, q=wdata[2].
REQ-025 Mid-BUSY reset: rst pulses during the second BUSY cycle -> q=00, qbar=FF, valid=0, busy=0; with req=1001 after release, first gnt=0001.
REQ-026 Withdrawn request: req[3] pulses for 1 cycle while BUSY -> no gnt[3] ever; q unchanged.
